// File: rtl/int_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller: register map,
// CTRL bit layout, vector width and small mask/word builders.
package int_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'b00;
    localparam logic [1:0] ADDR_EN    = 2'b01;
    localparam logic [1:0] ADDR_FLAG  = 2'b10;
    localparam logic [1:0] ADDR_SWSET = 2'b11;

    localparam int CTRL_GIE       = 0;
    localparam int CTRL_INSVC     = 1;
    localparam int CTRL_SVCVEC_LO = 4;
    localparam int CTRL_SVCVEC_HI = 6;

    localparam int VEC_W   = 3;
    localparam int MAX_SRC = 8;

    typedef logic [VEC_W-1:0]   intVec_t;
    typedef logic [MAX_SRC-1:0] srcVec_t;

    // Bits below numSrc are implemented; the rest stay 0.
    function automatic srcVec_t srcMask(input int numSrc);
        srcVec_t m;
        m = 8'h00;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < numSrc) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic srcVec_t vecOneHot(input intVec_t v);
        srcVec_t m;
        m    = 8'h00;
        m[v] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] ctrlWord(input logic gie, input logic insvc,
                                             input intVec_t svcVec);
        logic [15:0] w;
        w = 16'h0000;
        w[CTRL_GIE]                       = gie;
        w[CTRL_INSVC]                     = insvc;
        w[CTRL_SVCVEC_HI:CTRL_SVCVEC_LO]  = svcVec;
        return w;
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of an 8-bit request
// vector and whether any bit is set.
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [7:0]       req,
    output logic [VEC_W-1:0] vec,
    output logic             any
);

    // Index 0 has the highest priority; an empty vector encodes as 0.
    always_comb begin
        any = |req;
        casez (req)
            8'b???????1: vec = 3'd0;
            8'b??????10: vec = 3'd1;
            8'b?????100: vec = 3'd2;
            8'b????1000: vec = 3'd3;
            8'b???10000: vec = 3'd4;
            8'b??100000: vec = 3'd5;
            8'b?1000000: vec = 3'd6;
            8'b10000000: vec = 3'd7;
            default:     vec = 3'd0;
        endcase
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: edge-latched flags, enable mask,
// fixed-priority arbitration and an ack/done service handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [1:0]         i_memAddr,
    input  logic [15:0]        i_memDataIn,
    input  logic               i_memWrEn,
    output logic [15:0]        o_memDataOut,
    input  logic [NUM_SRC-1:0] i_intSrc,
    input  logic               i_intAck,
    input  logic               i_intDone,
    output logic               o_intReq,
    output logic [VEC_W-1:0]   o_intVec,
    output logic               o_wake
);

    localparam srcVec_t IMPL_MASK = srcMask(NUM_SRC);

    logic    gie_r;
    logic    insvc_r;
    intVec_t svcVec_r;
    srcVec_t en_r;
    srcVec_t flags_r;
    srcVec_t prev_r;
    logic    intReq_r;
    intVec_t intVec_r;

    srcVec_t srcPad_s;
    srcVec_t wrByte_s;
    srcVec_t setVec_s;
    srcVec_t clrVec_s;
    logic    wrCtrl_s;
    logic    wrEn_s;
    logic    wrFlag_s;
    logic    wrSwset_s;
    logic    ackTake_s;
    logic    gieNext_s;
    logic    insvcNext_s;
    intVec_t svcVecNext_s;
    srcVec_t enNext_s;
    srcVec_t flagsNext_s;
    srcVec_t pendingNext_s;
    intVec_t vecNext_s;
    logic    anyNext_s;
    srcVec_t pending_s;
    logic    unusedDin_s;

    if (NUM_SRC < MAX_SRC) begin : gPad
        assign srcPad_s = {{(MAX_SRC-NUM_SRC){1'b0}}, i_intSrc};
    end else begin : gFull
        assign srcPad_s = i_intSrc;
    end

    assign unusedDin_s = ^i_memDataIn[15:8];
    assign pending_s   = flags_r & en_r;

    // Next-state of every register; flag sets win over clears on the same bit.
    always_comb begin
        wrCtrl_s     = i_memWrEn && (i_memAddr == ADDR_CTRL);
        wrEn_s       = i_memWrEn && (i_memAddr == ADDR_EN);
        wrFlag_s     = i_memWrEn && (i_memAddr == ADDR_FLAG);
        wrSwset_s    = i_memWrEn && (i_memAddr == ADDR_SWSET);
        wrByte_s     = i_memDataIn[7:0] & IMPL_MASK;
        ackTake_s    = i_intAck && intReq_r;

        if (wrCtrl_s) begin
            gieNext_s = i_memDataIn[CTRL_GIE];
        end else begin
            gieNext_s = gie_r;
        end

        if (wrEn_s) begin
            enNext_s = wrByte_s;
        end else begin
            enNext_s = en_r;
        end

        setVec_s = srcPad_s & ~prev_r;
        if (wrSwset_s) begin
            setVec_s = setVec_s | wrByte_s;
        end else begin
            setVec_s = setVec_s;
        end

        clrVec_s = 8'h00;
        if (wrFlag_s) begin
            clrVec_s = clrVec_s | wrByte_s;
        end else begin
            clrVec_s = clrVec_s;
        end
        if (ackTake_s) begin
            clrVec_s = clrVec_s | vecOneHot(intVec_r);
        end else begin
            clrVec_s = clrVec_s;
        end

        flagsNext_s = ((flags_r & ~clrVec_s) | setVec_s) & IMPL_MASK;

        // Ack outranks a same-cycle done, so service stays active.
        if (ackTake_s) begin
            insvcNext_s  = 1'b1;
            svcVecNext_s = intVec_r;
        end else if (i_intDone) begin
            insvcNext_s  = 1'b0;
            svcVecNext_s = svcVec_r;
        end else begin
            insvcNext_s  = insvc_r;
            svcVecNext_s = svcVec_r;
        end

        pendingNext_s = flagsNext_s & enNext_s;
    end

    int_prio_enc uPrioEnc (
        .req (pendingNext_s),
        .vec (vecNext_s),
        .any (anyNext_s)
    );

    // Controller state plus request outputs, registered from next-state so
    // they track the flags with no extra cycle of latency.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            gie_r    <= 1'b0;
            insvc_r  <= 1'b0;
            svcVec_r <= 3'd0;
            en_r     <= 8'h00;
            flags_r  <= 8'h00;
            prev_r   <= 8'h00;
            intReq_r <= 1'b0;
            intVec_r <= 3'd0;
        end else begin
            gie_r    <= gieNext_s;
            insvc_r  <= insvcNext_s;
            svcVec_r <= svcVecNext_s;
            en_r     <= enNext_s;
            flags_r  <= flagsNext_s;
            prev_r   <= srcPad_s;
            intReq_r <= gieNext_s & ~insvcNext_s & anyNext_s;
            intVec_r <= vecNext_s;
        end
    end

    // Register read mux.
    always_comb begin
        case (i_memAddr)
            ADDR_CTRL:  o_memDataOut = ctrlWord(gie_r, insvc_r, svcVec_r);
            ADDR_EN:    o_memDataOut = {8'h00, en_r};
            ADDR_FLAG:  o_memDataOut = {8'h00, flags_r};
            ADDR_SWSET: o_memDataOut = {8'h00, pending_s};
            default:    o_memDataOut = 16'h0000;
        endcase
    end

    assign o_intReq = intReq_r;
    assign o_intVec = intVec_r;
    assign o_wake   = intReq_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

    logic        i_clk;
    logic        i_rstn;
    logic [1:0]  i_memAddr;
    logic [15:0] i_memDataIn;
    logic        i_memWrEn;
    logic [15:0] o_memDataOut;
    logic [7:0]  i_intSrc;
    logic        i_intAck;
    logic        i_intDone;
    logic        o_intReq;
    logic [2:0]  o_intVec;
    logic        o_wake;

    int total = 0;
    int bad   = 0;

    int_ctrl #(.NUM_SRC(8)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_memAddr    (i_memAddr),
        .i_memDataIn  (i_memDataIn),
        .i_memWrEn    (i_memWrEn),
        .o_memDataOut (o_memDataOut),
        .i_intSrc     (i_intSrc),
        .i_intAck     (i_intAck),
        .i_intDone    (i_intDone),
        .o_intReq     (o_intReq),
        .o_intVec     (o_intVec),
        .o_wake       (o_wake)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] addr, input logic [15:0] exp, input string tag);
        i_memAddr = addr;
        #1;
        chk(tag, o_memDataOut, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        i_memAddr   = addr;
        i_memDataIn = data;
        i_memWrEn   = 1'b1;
        tick();
        i_memWrEn   = 1'b0;
        i_memDataIn = 16'h0000;
    endtask

    task automatic reqChk(input logic req, input logic [2:0] vec, input string tag);
        chk({tag, ".req"},  {15'd0, o_intReq}, {15'd0, req});
        chk({tag, ".wake"}, {15'd0, o_wake},   {15'd0, req});
        chk({tag, ".vec"},  {13'd0, o_intVec}, {13'd0, vec});
    endtask

    initial begin
        i_rstn = 1'b0; i_memAddr = 2'b00; i_memDataIn = 16'h0000; i_memWrEn = 1'b0;
        i_intSrc = 8'h00; i_intAck = 1'b0; i_intDone = 1'b0;
        tick(); tick();

        // reset state
        reqChk(1'b0, 3'd0, "rst");
        rd(2'b00, 16'h0000, "rst.ctrl");
        rd(2'b01, 16'h0000, "rst.en");
        rd(2'b10, 16'h0000, "rst.flags");
        rd(2'b11, 16'h0000, "rst.pend");
        i_rstn = 1'b1;
        tick();

        // CTRL: only GIE is writable
        wr(2'b00, 16'hFFFF);
        rd(2'b00, 16'h0001, "ctrl.ro");

        // source 0 edge, one-cycle latency, ack
        wr(2'b01, 16'h0001);
        i_intSrc = 8'h01;
        tick();
        rd(2'b10, 16'h0001, "t1.flags");
        reqChk(1'b1, 3'd0, "t1.req");
        i_intAck = 1'b1; tick(); i_intAck = 1'b0;
        reqChk(1'b0, 3'd0, "t1.ack");
        rd(2'b00, 16'h0003, "t1.ctrl");
        rd(2'b10, 16'h0000, "t1.flagsclr");
        i_intSrc = 8'h00;
        i_intDone = 1'b1; tick(); i_intDone = 1'b0;
        rd(2'b00, 16'h0001, "t1.done");

        // SWSET 0x24: vector 2, then 5 after service
        wr(2'b01, 16'h00FF);
        wr(2'b11, 16'h0024);
        reqChk(1'b1, 3'd2, "t2.sw");
        rd(2'b11, 16'h0024, "t2.pend");
        i_intAck = 1'b1; tick(); i_intAck = 1'b0;
        reqChk(1'b0, 3'd5, "t2.ack");
        rd(2'b00, 16'h0023, "t2.ctrl");
        rd(2'b10, 16'h0020, "t2.flags");
        i_intDone = 1'b1; tick(); i_intDone = 1'b0;
        reqChk(1'b1, 3'd5, "t2.done");
        rd(2'b00, 16'h0021, "t2.ctrl2");

        // no nesting; ack without request ignored
        i_intAck = 1'b1; tick(); i_intAck = 1'b0;
        rd(2'b00, 16'h0053, "t3.ctrl");
        i_intSrc = 8'h08;
        tick();
        reqChk(1'b0, 3'd3, "t3.insvc");
        rd(2'b10, 16'h0008, "t3.flags");
        i_intAck = 1'b1; tick(); i_intAck = 1'b0;
        rd(2'b00, 16'h0053, "t3.ackign");
        rd(2'b10, 16'h0008, "t3.ackflag");
        i_intDone = 1'b1; tick(); i_intDone = 1'b0;
        reqChk(1'b1, 3'd3, "t3.done");

        // W1C vs. same-cycle edge: set wins
        i_intSrc = 8'h00;
        tick();
        i_intSrc = 8'h08;
        wr(2'b10, 16'h0008);
        rd(2'b10, 16'h0008, "t4.setwins");
        // write 0 leaves flags alone
        wr(2'b10, 16'h0000);
        rd(2'b10, 16'h0008, "t4.w0");

        // ack and done together: ack wins
        i_intAck = 1'b1; i_intDone = 1'b1; tick(); i_intAck = 1'b0; i_intDone = 1'b0;
        rd(2'b00, 16'h0033, "t4.ackdone");
        rd(2'b10, 16'h0000, "t4.flags");
        reqChk(1'b0, 3'd0, "t4.req");
        i_intDone = 1'b1; tick(); i_intDone = 1'b0;
        rd(2'b00, 16'h0031, "t4.done");

        // GIE gating
        wr(2'b00, 16'h0000);
        wr(2'b11, 16'h0010);
        reqChk(1'b0, 3'd4, "t5.gie0");
        rd(2'b11, 16'h0010, "t5.pend");
        wr(2'b00, 16'h0001);
        reqChk(1'b1, 3'd4, "t5.gie1");

        // W1C clears pending
        wr(2'b10, 16'h0010);
        reqChk(1'b0, 3'd0, "t5.w1c");
        wr(2'b11, 16'h0010);
        reqChk(1'b1, 3'd4, "t5.reset");

        // reset during service, source 0 held across release
        i_intAck = 1'b1; tick(); i_intAck = 1'b0;
        rd(2'b00, 16'h0043, "t6.svc");
        i_intSrc = 8'h01;
        i_rstn = 1'b0;
        tick();
        reqChk(1'b0, 3'd0, "t6.rst");
        rd(2'b00, 16'h0000, "t6.ctrl");
        rd(2'b01, 16'h0000, "t6.en");
        rd(2'b10, 16'h0000, "t6.flags");
        rd(2'b11, 16'h0000, "t6.pend");
        i_rstn = 1'b1;
        tick();
        rd(2'b10, 16'h0001, "t6.heldsrc");
        reqChk(1'b0, 3'd0, "t6.noreq");
        wr(2'b01, 16'h0001);
        wr(2'b00, 16'h0001);
        reqChk(1'b1, 3'd0, "t6.enable");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
